// File: rtl/baz_gen.sv
// Serial burst generator: emits reps+1 three-bit frames ("baz" 101 or "owa" 110)
// with a programmable idle gap between frames, then a one-cycle done pulse.
module baz_gen #(
    parameter int GAP_W = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sel,
    input  logic [REP_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         bitIdx_q, bitIdx_d;
    logic [REP_W-1:0]   frameCnt_q, frameCnt_d;
    logic [GAP_W-1:0]   gapCnt_q, gapCnt_d;
    logic [GAP_W-1:0]   gapLat_q, gapLat_d;
    logic               selLat_q, selLat_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bitIdx_q   <= '0;
            frameCnt_q <= '0;
            gapCnt_q   <= '0;
            gapLat_q   <= '0;
            selLat_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitIdx_q   <= bitIdx_d;
            frameCnt_q <= frameCnt_d;
            gapCnt_q   <= gapCnt_d;
            gapLat_q   <= gapLat_d;
            selLat_q   <= selLat_d;
        end
    end

    // frameCnt_q holds the number of frames still to send after the current one
    always_comb begin
        state_d    = state_q;
        bitIdx_d   = bitIdx_q;
        frameCnt_d = frameCnt_q;
        gapCnt_d   = gapCnt_q;
        gapLat_d   = gapLat_q;
        selLat_d   = selLat_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    selLat_d   = sel;
                    gapLat_d   = gap;
                    frameCnt_d = reps;
                    bitIdx_d   = 2'd0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (bitIdx_q != 2'd2) begin
                    bitIdx_d = bitIdx_q + 2'd1;
                end else begin
                    bitIdx_d = 2'd0;
                    if (frameCnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        frameCnt_d = frameCnt_q - 1'b1;
                        if (gapLat_q == '0) begin
                            state_d = SEND;
                        end else begin
                            gapCnt_d = gapLat_q;
                            state_d  = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (gapCnt_q <= GAP_W'(1)) begin
                    gapCnt_d = '0;
                    state_d  = SEND;
                end else begin
                    gapCnt_d = gapCnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs depend only on registered state, never on the inputs
    always_comb begin
        out   = 1'b0;
        valid = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;

        case (state_q)
            SEND: begin
                valid = 1'b1;
                busy  = 1'b1;
                case (bitIdx_q)
                    2'd0:    out = 1'b1;
                    2'd1:    out = selLat_q;
                    2'd2:    out = ~selLat_q;
                    default: out = 1'b0;
                endcase
            end
            GAP: begin
                busy = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                out = 1'b0;
            end
        endcase
    end

endmodule
